// File: rtl/uart_pkg.sv
// uart_pkg -- shared types and helpers for the UART blocks.
//   rx_state_t      : receiver FSM states
//   baud16_divisor(): clocks per 16x oversampling tick
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  // Integer division truncates: 50 MHz / (115200*16) -> 27.
  function automatic int baud16_divisor(input int clk_freq, input int baud_rate);
    return clk_freq / (baud_rate * 16);
  endfunction

endpackage

// File: rtl/uart_rx16_if.sv
// uart_rx16_if -- received-byte handshake.
//   rx_data  : received byte (master -> slave)
//   rx_valid : rx_data holds an unread byte (master -> slave)
//   rx_ready : consumer accepts the byte (slave -> master)
interface uart_rx16_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/baud16_tick.sv
// baud16_tick -- 16x baud enable generator, shared by receiver and transmitter.
//   clk     : system clock
//   reset_n : synchronous active-low reset
//   tick16  : one-cycle enable every DIVISOR clocks (asserted on the wrap cycle)
module baud16_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick16
);

  localparam int DIVISOR = baud16_divisor(CLK_FREQ, BAUD_RATE);
  localparam int CW      = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;

  if (DIVISOR < 2) begin : g_div_chk
    $error("baud16_tick: DIVISOR (%0d) must be at least 2", DIVISOR);
  end

  logic [CW-1:0] cnt_q;
  logic          wrap;

  assign wrap   = (cnt_q == CW'(DIVISOR - 1));
  assign tick16 = wrap;

  always_ff @(posedge clk) begin
    if (!reset_n)  cnt_q <= '0;
    else if (wrap) cnt_q <= '0;
    else           cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/uart_rx16.sv
// uart_rx16 -- 16x oversampling UART receiver, 8 data bits, optional parity.
//   clk         : system clock (rising edge)
//   reset_n     : synchronous active-low reset
//   rx          : asynchronous serial line, idle high
//   bus         : rx_data / rx_valid / rx_ready handshake (master side)
//   frame_err   : sticky, stop bit sampled low
//   parity_err  : sticky, parity mismatch
//   overrun_err : sticky, byte completed while previous one unread
//   err_clr     : pulse clearing the sticky flags (a same-cycle set wins)
module uart_rx16
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx,
  uart_rx16_if.master bus,
  output logic        frame_err,
  output logic        parity_err,
  output logic        overrun_err,
  input  logic        err_clr
);

  localparam logic PODD = (PARITY_ODD != 0);

  logic       tick16;
  logic [1:0] sync_q;
  logic       rx_s;
  rx_state_t  state_q;
  logic [3:0] smp_q;
  logic [2:0] bit_q;
  logic [7:0] shreg_q;
  logic [7:0] data_q;
  logic       valid_q;
  logic       ferr_q, perr_q, oerr_q;

  logic mid_bit, stop_ok, stop_bad, par_bad, accept;

  baud16_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick16  (tick16)
  );

  // Two-flop synchronizer; resets high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], rx};
  end
  assign rx_s = sync_q[1];

  // Sample counter is cleared at mid-start, so the 16th tick after that
  // (count 15) lands in the middle of every following bit.
  assign mid_bit  = tick16 && (smp_q == 4'd15);
  assign stop_ok  = (state_q == STOP)   && mid_bit &&  rx_s;
  assign stop_bad = (state_q == STOP)   && mid_bit && !rx_s;
  assign par_bad  = (state_q == PARITY) && mid_bit && (rx_s != ((^shreg_q) ^ PODD));
  assign accept   = valid_q && bus.rx_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      smp_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      if (tick16) begin
        case (state_q)
          IDLE: begin
            if (!rx_s) begin
              state_q <= START;
              smp_q   <= '0;
            end
          end
          START: begin
            if (smp_q == 4'd7) begin
              if (rx_s) begin
                state_q <= IDLE;          // false start, drop silently
              end else begin
                state_q <= DATA;
                smp_q   <= '0;
                bit_q   <= '0;
              end
            end else begin
              smp_q <= smp_q + 4'd1;
            end
          end
          DATA: begin
            smp_q <= smp_q + 4'd1;        // 15 -> 0 wrap starts next bit
            if (smp_q == 4'd15) begin
              shreg_q <= {rx_s, shreg_q[7:1]};
              bit_q   <= bit_q + 3'd1;
              if (bit_q == 3'd7)
                state_q <= (PARITY_EN != 0) ? PARITY : STOP;
            end
          end
          PARITY: begin
            smp_q <= smp_q + 4'd1;
            if (smp_q == 4'd15) state_q <= STOP;
          end
          STOP: begin
            // Leave at mid-stop so the next start edge is caught early.
            smp_q <= smp_q + 4'd1;
            if (smp_q == 4'd15) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end

      // A new byte wins over an accept in the same cycle.
      if (stop_ok) begin
        data_q  <= shreg_q;
        valid_q <= 1'b1;
      end else if (accept) begin
        valid_q <= 1'b0;
      end

      if (stop_ok && valid_q && !bus.rx_ready) oerr_q <= 1'b1;
      else if (err_clr)                        oerr_q <= 1'b0;

      if (stop_bad)     ferr_q <= 1'b1;
      else if (err_clr) ferr_q <= 1'b0;

      if (par_bad)      perr_q <= 1'b1;
      else if (err_clr) perr_q <= 1'b0;
    end
  end

  assign bus.rx_data  = data_q;
  assign bus.rx_valid = valid_q;
  assign frame_err    = ferr_q;
  assign parity_err   = perr_q;
  assign overrun_err  = oerr_q;

endmodule

// File: tb/tb_uart_rx16.sv
// tb_uart_rx16 -- directed bench for uart_rx16: 8N1 instance (dut) and
// even-parity instance (dut_p), each on its own serial line.
module tb_uart_rx16;
  import uart_pkg::*;

  localparam int BIT_CLK = 432;

  logic clk;
  logic reset_n;
  logic err_clr;
  logic rx0, rx1;
  logic ferr0, perr0, oerr0;
  logic ferr1, perr1, oerr1;

  uart_rx16_if if0 ();
  uart_rx16_if if1 ();

  uart_rx16 dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx          (rx0),
    .bus         (if0),
    .frame_err   (ferr0),
    .parity_err  (perr0),
    .overrun_err (oerr0),
    .err_clr     (err_clr)
  );

  uart_rx16 #(.PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx          (rx1),
    .bus         (if1),
    .frame_err   (ferr1),
    .parity_err  (perr1),
    .overrun_err (oerr1),
    .err_clr     (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Log of bytes accepted on the 8N1 handshake.
  int         acc_cnt = 0;
  logic [7:0] acc_log [8];
  always @(posedge clk) begin
    if (if0.rx_valid && if0.rx_ready) begin
      acc_log[acc_cnt[2:0]] <= if0.rx_data;
      acc_cnt <= acc_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input int line, input logic v, input int clks);
    if (line == 0) rx0 = v;
    else           rx1 = v;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input int line, input logic [7:0] b, input bit par_en,
                            input logic par_bit, input logic stop_bit);
    drive_bit(line, 1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) drive_bit(line, b[i], BIT_CLK);
    if (par_en) drive_bit(line, par_bit, BIT_CLK);
    drive_bit(line, stop_bit, BIT_CLK);
    if (line == 0) rx0 = 1'b1;
    else           rx1 = 1'b1;
  endtask

  // Bounded wait; the caller's rx_valid check reports an expired bound.
  task automatic wait_valid(input int line, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((line == 0 && if0.rx_valid) || (line == 1 && if1.rx_valid)) break;
      @(negedge clk);
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  int base;

  initial begin
    rx0 = 1'b1; rx1 = 1'b1;
    reset_n = 1'b0; err_clr = 1'b0;
    if0.rx_ready = 1'b0; if1.rx_ready = 1'b0;
    repeat (5) @(negedge clk);

    // Reset state
    chk("rst_data",  32'(if0.rx_data), 32'h00);
    chk("rst_valid", 32'(if0.rx_valid), 32'd0);
    chk("rst_flags", 32'({ferr0, perr0, oerr0}), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    reset_n = 1'b1;
    repeat (BIT_CLK) @(negedge clk);

    // 0xA5 8N1, consumer not ready
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    wait_valid(0, 2 * BIT_CLK);
    chk("a5_valid", 32'(if0.rx_valid), 32'd1);
    chk("a5_data",  32'(if0.rx_data), 32'hA5);
    chk("a5_flags", 32'({ferr0, perr0, oerr0}), 32'd0);
    repeat (100) @(negedge clk);
    chk("a5_stable", 32'(if0.rx_data), 32'hA5);
    if0.rx_ready = 1'b1;
    @(negedge clk);
    if0.rx_ready = 1'b0;
    chk("a5_accept", 32'(if0.rx_valid), 32'd0);

    // 100-clk low glitch
    drive_bit(0, 1'b0, 100);
    drive_bit(0, 1'b1, 2 * BIT_CLK);
    chk("glitch_state", 32'(dut.state_q), 32'(IDLE));
    chk("glitch_valid", 32'(if0.rx_valid), 32'd0);
    chk("glitch_flags", 32'({ferr0, perr0, oerr0}), 32'd0);

    // 0x3C with a low stop bit
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    drive_bit(0, 1'b1, 2 * BIT_CLK);
    chk("ferr_set",   32'(ferr0), 32'd1);
    chk("ferr_valid", 32'(if0.rx_valid), 32'd0);
    chk("ferr_data",  32'(if0.rx_data), 32'hA5);
    pulse_clr();
    chk("ferr_clr",   32'(ferr0), 32'd0);

    // Back-to-back 0x11, 0x22 with rx_ready low -> overrun
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    wait_valid(0, 2 * BIT_CLK);
    chk("b2b_first",  32'(if0.rx_data), 32'h11);
    chk("b2b_no_ovr", 32'(oerr0), 32'd0);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    chk("ovr_set",   32'(oerr0), 32'd1);
    chk("ovr_data",  32'(if0.rx_data), 32'h22);
    chk("ovr_valid", 32'(if0.rx_valid), 32'd1);

    // Reset during data bit 4 of 0x0F (bit 4 is low)
    drive_bit(0, 1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'b1, BIT_CLK);
    drive_bit(0, 1'b0, 200);
    reset_n = 1'b0;
    repeat (10) @(negedge clk);
    rx0 = 1'b1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("mrst_data",  32'(if0.rx_data), 32'h00);
    chk("mrst_valid", 32'(if0.rx_valid), 32'd0);
    chk("mrst_flags", 32'({ferr0, perr0, oerr0}), 32'd0);
    chk("mrst_state", 32'(dut.state_q), 32'(IDLE));
    repeat (2 * BIT_CLK) @(negedge clk);
    chk("mrst_quiet", 32'(if0.rx_valid), 32'd0);
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    wait_valid(0, 2 * BIT_CLK);
    chk("5a_valid", 32'(if0.rx_valid), 32'd1);
    chk("5a_data",  32'(if0.rx_data), 32'h5A);
    chk("5a_flags", 32'({ferr0, perr0, oerr0}), 32'd0);

    // rx_ready held high: both bytes accepted, no overrun
    if0.rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    base = acc_cnt;
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    chk("rdy_count", 32'(acc_cnt - base), 32'd2);
    chk("rdy_byte0", 32'(acc_log[base % 8]), 32'h11);
    chk("rdy_byte1", 32'(acc_log[(base + 1) % 8]), 32'h22);
    chk("rdy_no_ovr", 32'(oerr0), 32'd0);
    chk("rdy_valid", 32'(if0.rx_valid), 32'd0);
    if0.rx_ready = 1'b0;

    // Even parity: 0x07 with parity bit 0 is a mismatch, still delivered
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
    wait_valid(1, 2 * BIT_CLK);
    chk("par_valid", 32'(if1.rx_valid), 32'd1);
    chk("par_data",  32'(if1.rx_data), 32'h07);
    chk("par_err",   32'(perr1), 32'd1);
    chk("par_ferr",  32'(ferr1), 32'd0);
    pulse_clr();
    if1.rx_ready = 1'b1;
    @(negedge clk);
    if1.rx_ready = 1'b0;
    chk("par_clr", 32'(perr1), 32'd0);

    // 0x03 with parity bit 0 is correct even parity
    send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1);
    wait_valid(1, 2 * BIT_CLK);
    chk("par_ok_valid", 32'(if1.rx_valid), 32'd1);
    chk("par_ok_data",  32'(if1.rx_data), 32'h03);
    chk("par_ok_err",   32'(perr1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
